keypad_dac_entry: RTL and testbench
===================================

// Module: keypad_dac_entry
// PURPOSE
//   Scans a 4x4 hex matrix keypad, debounces it and turns each accepted keypress into a hex nibble.
//   Each accepted nibble is shifted into an 8-bit DAC setpoint register.
//   It is the input-side counterpart of the multiplexed 7-segment DAC display. dac_val drives both
//   the DAC and the display, so the operator enters a value with two keypresses (high nibble, then low).
// PARAMETERS
//   SCAN_CLK        100000  column dwell = SCAN_CLK+1 clk cycles; legal range >= 3
//   DEBOUNCE_SCANS  4       consecutive identical full-scan frames needed to accept a press or a release; 1..15
// PORTS
//   clk          in   1  system clock; all logic on posedge
//   rst          in   1  asynchronous, active-low reset
//   key_row      in   4  keypad rows; active-low, external pull-ups; asynchronous to clk
//   dac_clr      in   1  synchronous clear of dac_val; single-cycle pulse or level
//   key_col      out  4  keypad column drive; one-hot-low
//   key_code     out  4  last accepted key, hex 0..F
//   key_valid    out  1  one-cycle pulse per accepted key
//   key_pressed  out  1  high while an accepted key is held (HELD or RELEASE state)
//   dac_val      out  8  DAC setpoint; {old[3:0], new key} on each accept
// BEHAVIOUR
//   Reset (rst low, async):
//     key_col=4'b1110, key_code=0, key_valid=0, key_pressed=0, dac_val=8'h00.
//     Row synchronizer=4'hF, dwell counter=0, frame accumulators cleared, state=IDLE.
//   Input sync: key_row passes through a 2-flop synchronizer before any use.
//   Scan:
//     Dwell counter runs 0..SCAN_CLK.
//     When counter==SCAN_CLK: sample the synced rows for the current column, then rotate key_col
//       left (1110->1101->1011->0111->1110) and clear the counter.
//     Column index c = position of the 0 bit in key_col (0..3).
//   Frame: the 4 consecutive samples, column 0 to column 3. Frame end = the sample cycle of column 3.
//   Key code = {row_idx[1:0], col_idx[1:0]}, where row_idx is the low row bit.
//   Per-frame result:
//     NONE   = no low row in any column.
//     SINGLE = exactly one row/column hit in the whole frame; yields that code.
//     MULTI  = more than one hit; handled the same as NONE for acceptance.
//       Exception: in HELD/RELEASE, MULTI counts as "key down".
//   FSM: evaluated only at frame end; stable between frame ends.
//     IDLE:     SINGLE -> latch cand=code, cnt=1; go to DEBOUNCE.
//               If DEBOUNCE_SCANS==1, accept immediately and go to HELD.
//     DEBOUNCE: SINGLE with code==cand -> cnt++; if cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
//               Any other result (NONE, MULTI, different code) -> IDLE, cnt=0.
//     HELD:     NONE -> RELEASE, cnt=1 (or straight to IDLE if DEBOUNCE_SCANS==1).
//               Any hit -> stay. No auto-repeat.
//     RELEASE:  NONE -> cnt++; if cnt reaches DEBOUNCE_SCANS, go to IDLE.
//               Any hit -> HELD, cnt=0.
//   Accept:
//     In the clk cycle after the frame-end sample cycle: key_valid=1 for exactly one cycle,
//       key_code<=cand, dac_val<={dac_val[3:0],cand}.
//     Accept latency = 1 cycle after the frame-end sample cycle.
//   dac_clr:
//     Sets dac_val=0 the next cycle.
//     If it coincides with an accept, clear wins: dac_val=0, but key_valid still pulses and key_code
//       still updates.
//     It does not affect the FSM or the scan.
//   key_pressed: registered; =1 exactly while state is HELD or RELEASE.
//   Counters saturate: no wrap of cnt beyond DEBOUNCE_SCANS.
//     The dwell counter is wide enough for SCAN_CLK (>=17 bits at default).
//   Reset mid-operation: everything returns to reset values immediately; any partial frame is discarded.
//     The first frame after reset starts at column 0.
// TESTING  (SCAN_CLK=3, DEBOUNCE_SCANS=3 -> 4-cycle dwell, 16-cycle frame; bench keypad model pulls
//           row r low while col c is driven low)
//   1. Reset release, no keys
//        -> key_col steps 1110,1101,1011,0111,1110 every 4 cycles.
//        -> all outputs 0; key_valid never pulses.
//   2. Hold key 6 (row1,col2) for 3 whole frames
//        -> exactly one key_valid pulse, key_code=6, dac_val=8'h06.
//      Release, then press key A
//        -> dac_val=8'h6A.
//   3. Key 5 pressed for 2 frames, released 1 frame, pressed 2 frames
//        -> no key_valid; dac_val unchanged.
//   4. Hold key 3 for 20 frames, release for 2 frames, re-press for 5 frames
//        -> exactly one key_valid; key_pressed stays 1 throughout.
//      Release for 3 frames
//        -> key_pressed=0.
//   5. Keys 1 and 9 held together for 5 frames from IDLE
//        -> no key_valid; key_pressed=0.
//   6a. dac_clr asserted in the accept cycle of key F, with dac_val=8'h12
//        -> key_valid=1, key_code=F, dac_val=8'h00.
//   6b. rst pulsed low mid-DEBOUNCE
//        -> reset values; a new 3-frame press is required to accept.

Source files
------------

// File: rtl/keypad_dac_entry_if.sv
// Keypad / DAC-setpoint signal bundle between the keypad entry block and its host.
// The slave side is the entry block; the master side owns the keypad rows and the clear.
interface keypad_dac_entry_if;
    logic [3:0] key_row;
    logic       dac_clr;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;
    logic [7:0] dac_val;

    modport master (
        output key_row, dac_clr,
        input  key_col, key_code, key_valid, key_pressed, dac_val
    );

    modport slave (
        input  key_row, dac_clr,
        output key_col, key_code, key_valid, key_pressed, dac_val
    );
endinterface

// File: rtl/keypad_dac_entry.sv
// 4x4 hex keypad scanner with frame-based debounce; each accepted key is shifted
// into an 8-bit DAC setpoint as the new low nibble.
module keypad_dac_entry #(
    parameter int SCAN_CLK       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic              clk,
    input logic              rst,
    keypad_dac_entry_if.slave kp
);
    localparam int DW = $clog2(SCAN_CLK + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    // hits saturates at 2: 0 = none, 1 = single, 2 = multi
    typedef struct packed {
        logic [1:0] hits;
        logic [3:0] code;
    } frame_acc_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    frame_acc_t    acc, base, tot;
    logic [2:0]    n_lo;
    logic [1:0]    row_idx;
    logic          sample, frame_end, f_none, f_single;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt, cnt_inc, cand, cand_nxt;
    logic       accept;

    logic [3:0] key_code_r;
    logic       key_valid_r, key_pressed_r;
    logic [7:0] dac_val_r;

    assign sample    = (dwell == DW'(SCAN_CLK));
    assign frame_end = sample && (col == 2'd3);
    assign f_none    = (tot.hits == 2'd0);
    assign f_single  = (tot.hits == 2'd1);
    assign cnt_inc   = cnt + 4'd1;

    // Fold this column's sample into the running frame; column 0 starts a fresh frame.
    always_comb begin
        base    = (col == 2'd0) ? '0 : acc;
        n_lo    = '0;
        row_idx = '0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2[r]) begin
                n_lo    = n_lo + 3'd1;
                row_idx = 2'(r);
            end
        end
        tot = base;
        if (n_lo != 3'd0) begin
            if (base.hits == 2'd0 && n_lo == 3'd1) begin
                tot.hits = 2'd1;
                tot.code = {row_idx, col};
            end else begin
                tot.hits = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
            dwell  <= '0;
            col    <= '0;
            acc    <= '0;
        end else begin
            row_s1 <= kp.key_row;
            row_s2 <= row_s1;
            if (sample) begin
                dwell <= '0;
                col   <= col + 2'd1;
                acc   <= tot;
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    assign kp.key_col = ~(4'b0001 << col);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        accept    = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: if (f_single) begin
                    cand_nxt = tot.code;
                    if (DEBOUNCE_SCANS == 1) begin
                        accept    = 1'b1;
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DEBOUNCE;
                        cnt_nxt   = 4'd1;
                    end
                end
                DEBOUNCE: if (f_single && tot.code == cand) begin
                    if (cnt_inc >= 4'(DEBOUNCE_SCANS)) begin
                        accept    = 1'b1;
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
                // A multi-key frame still counts as "key down" once a key is held.
                HELD: if (f_none) begin
                    if (DEBOUNCE_SCANS == 1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = RELEASE;
                        cnt_nxt   = 4'd1;
                    end
                end
                RELEASE: if (f_none) begin
                    if (cnt_inc >= 4'(DEBOUNCE_SCANS)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cand          <= '0;
            key_code_r    <= '0;
            key_valid_r   <= 1'b0;
            key_pressed_r <= 1'b0;
            dac_val_r     <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            cand          <= cand_nxt;
            key_valid_r   <= accept;
            key_pressed_r <= (state_nxt == HELD) || (state_nxt == RELEASE);
            if (accept) key_code_r <= cand_nxt;
            // Clear takes priority over a coincident accept.
            if (kp.dac_clr)   dac_val_r <= '0;
            else if (accept)  dac_val_r <= {dac_val_r[3:0], cand_nxt};
        end
    end

    assign kp.key_code    = key_code_r;
    assign kp.key_valid   = key_valid_r;
    assign kp.key_pressed = key_pressed_r;
    assign kp.dac_val     = dac_val_r;
endmodule

// File: tb/tb_keypad_dac_entry.sv
// Bench for keypad_dac_entry: keypad matrix model, cycle-level behavioural model
// compared every cycle, and directed scenarios with literal expectations.
module tb_keypad_dac_entry;
    localparam int DS = 3;
    localparam int S_IDLE = 0, S_DEB = 1, S_HELD = 2, S_REL = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_dac_entry_if kif();
    keypad_dac_entry #(.SCAN_CLK(3), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst(rst), .kp(kif.slave)
    );

    logic [15:0] keys;
    int checks = 0, passed = 0;
    int pulses = 0;
    bit watch = 0, drop = 0;

    // Keypad: row r reads low while a pressed key (r,c) has its column driven low.
    always_comb begin
        kif.key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.key_col[c]) kif.key_row[r] = 1'b0;
    end

    // Behavioural model state (values describe the current cycle).
    int m_dwell, m_col, m_st, m_cnt;
    logic [3:0] m_cand, e_code;
    logic e_valid, e_pressed;
    logic [7:0] e_dac;
    logic [3:0] h1, h2;
    int fq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_dwell = 0; m_col = 0; m_st = S_IDLE; m_cnt = 0; m_cand = 0;
        e_code = 0; e_valid = 0; e_pressed = 0; e_dac = 0;
        h1 = 4'hF; h2 = 4'hF;
        fq.delete();
    endtask

    task automatic do_accept();
        m_st = S_HELD; m_cnt = 0;
        e_valid = 1; e_code = m_cand;
        e_dac = {e_dac[3:0], m_cand};
    endtask

    task automatic frame_rules();
        int n;
        n = fq.size();
        case (m_st)
            S_IDLE: if (n == 1) begin
                m_cand = 4'(fq[0]); m_cnt = 1; m_st = S_DEB;
                if (m_cnt >= DS) do_accept();
            end
            S_DEB: if (n == 1 && 4'(fq[0]) == m_cand) begin
                m_cnt++;
                if (m_cnt >= DS) do_accept();
            end else begin
                m_st = S_IDLE; m_cnt = 0;
            end
            S_HELD: if (n == 0) begin
                m_st = S_REL; m_cnt = 1;
                if (m_cnt >= DS) begin m_st = S_IDLE; m_cnt = 0; end
            end
            default: if (n == 0) begin
                m_cnt++;
                if (m_cnt >= DS) begin m_st = S_IDLE; m_cnt = 0; end
            end else begin
                m_st = S_HELD; m_cnt = 0;
            end
        endcase
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step();
        logic [3:0] rows_now;
        rows_now = 4'hF;
        for (int r = 0; r < 4; r++)
            if (keys[r*4+m_col]) rows_now[r] = 1'b0;
        e_valid = 0;
        if (m_dwell == 3) begin
            if (m_col == 0) fq.delete();
            for (int r = 0; r < 4; r++)
                if (!h2[r]) fq.push_back(r*4 + m_col);
            if (m_col == 3) frame_rules();
        end
        if (kif.dac_clr) e_dac = 0;
        e_pressed = (m_st == S_HELD) || (m_st == S_REL);
        h2 = h1; h1 = rows_now;
        if (m_dwell == 3) begin m_dwell = 0; m_col = (m_col + 1) % 4; end
        else m_dwell++;
    endtask

    task automatic check_outs(input string name);
        logic [3:0] ecol;
        ecol = 4'hF;
        ecol[m_col] = 1'b0;
        check(name,
              {14'd0, kif.key_col, kif.key_code, kif.key_valid, kif.key_pressed, kif.dac_val},
              {14'd0, ecol, e_code, e_valid, e_pressed, e_dac});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            model_reset();
            check_outs("reset_state");
        end else begin
            check_outs("model_cycle");
            if (kif.key_valid) pulses++;
            if (watch && !kif.key_pressed) drop = 1;
            model_step();
        end
    end

    task automatic sync_frame();
        int k;
        for (k = 0; k < 40; k++) begin
            if (m_dwell == 0 && m_col == 0) break;
            @(posedge clk); #1;
        end
        if (k == 40) check("frame_align_timeout", 1, 0);
    endtask

    task automatic hold(input logic [15:0] k, input int frames);
        keys = k;
        repeat (16*frames) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] colseq [4];
        int p0;
        colseq[0] = 4'b1101; colseq[1] = 4'b1011; colseq[2] = 4'b0111; colseq[3] = 4'b1110;
        keys = '0;
        kif.dac_clr = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_col", kif.key_col, 4'b1110);
        check("rst_outs", {kif.key_code, kif.key_valid, kif.key_pressed, kif.dac_val}, 14'd0);
        rst = 1'b1;

        // 1. column rotation with no keys
        check("scan_col0", kif.key_col, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(posedge clk);
            #1;
            check("scan_rotate", kif.key_col, colseq[i]);
        end
        check("idle_no_pulse", pulses, 0);

        // 2. key 6 then key A
        sync_frame();
        p0 = pulses;
        hold(16'h1 << 6, 3);
        check("k6_valid", kif.key_valid, 1);
        check("k6_code", kif.key_code, 4'h6);
        check("k6_dac", kif.dac_val, 8'h06);
        hold(16'h0, 3);
        check("k6_one_pulse", pulses - p0, 1);
        check("k6_released", kif.key_pressed, 0);
        hold(16'h1 << 10, 3);
        check("kA_dac", kif.dac_val, 8'h6A);
        hold(16'h0, 3);

        // 3. bouncy key 5 never accepted
        p0 = pulses;
        hold(16'h1 << 5, 2);
        hold(16'h0, 1);
        hold(16'h1 << 5, 2);
        hold(16'h0, 1);
        check("k5_no_pulse", pulses - p0, 0);
        check("k5_dac_kept", kif.dac_val, 8'h6A);

        // 4. long hold, short release, re-press
        p0 = pulses;
        hold(16'h1 << 3, 20);
        watch = 1; drop = 0;
        hold(16'h0, 2);
        hold(16'h1 << 3, 5);
        check("k3_pressed_held", kif.key_pressed, 1);
        watch = 0;
        check("k3_no_drop", drop, 0);
        check("k3_one_pulse", pulses - p0, 1);
        hold(16'h0, 3);
        check("k3_released", kif.key_pressed, 0);
        check("k3_dac", kif.dac_val, 8'hA3);

        // 5. two keys together from idle
        p0 = pulses;
        hold((16'h1 << 1) | (16'h1 << 9), 5);
        check("multi_no_pulse", pulses - p0, 0);
        check("multi_not_pressed", kif.key_pressed, 0);
        hold(16'h0, 1);

        // 6a. clear, build 0x12, then clear in the accept cycle of key F
        kif.dac_clr = 1'b1;
        @(posedge clk); #1;
        kif.dac_clr = 1'b0;
        check("clr_dac", kif.dac_val, 8'h00);
        sync_frame();
        hold(16'h1 << 1, 3);
        hold(16'h0, 3);
        hold(16'h1 << 2, 3);
        hold(16'h0, 3);
        check("k12_dac", kif.dac_val, 8'h12);
        keys = 16'h1 << 15;
        repeat (47) @(posedge clk);
        #1 kif.dac_clr = 1'b1;
        @(posedge clk); #1;
        kif.dac_clr = 1'b0;
        check("kF_valid", kif.key_valid, 1);
        check("kF_code", kif.key_code, 4'hF);
        check("kF_clr_wins", kif.dac_val, 8'h00);
        hold(16'h0, 3);

        // 6b. reset in the middle of debouncing key 7
        p0 = pulses;
        keys = 16'h1 << 7;
        repeat (16*2 + 5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_col", kif.key_col, 4'b1110);
        check("mid_rst_outs", {kif.key_code, kif.key_valid, kif.key_pressed, kif.dac_val}, 14'd0);
        rst = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        check("k7_not_yet", pulses - p0, 0);
        repeat (16) @(posedge clk);
        #1;
        check("k7_valid", kif.key_valid, 1);
        check("k7_code", kif.key_code, 4'h7);
        check("k7_dac", kif.dac_val, 8'h07);
        hold(16'h0, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
